inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the instruction-buffer entries and the maximum number of in-flight imem requests.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the asynchronous, active-high reset.
REQ-005 SHALL have port imem_req, output, 1, meaning the fetch request is valid.
REQ-006 SHALL have port imem_addr, output, 32, meaning the fetch address, word-aligned.
REQ-007 SHALL have port imem_ready, input, 1, meaning imem accepts the request this cycle.
REQ-008 SHALL have port imem_rvalid, input, 1, meaning imem returns a response this cycle; responses return in order, latency >= 1 cycle.
REQ-009 SHALL have port imem_rdata, input, 32, meaning the returned instruction word.
REQ-010 SHALL have port redirect_valid, input, 1, meaning branch, jump or JALR redirect from execute.
REQ-011 SHALL have port redirect_pc, input, 32, meaning the redirect target.
REQ-012 SHALL have port inst_valid, output, 1, meaning an instruction is presented to decode and the immediate generator.
REQ-013 SHALL have port inst_ready, input, 1, meaning decode accepts the instruction this cycle.
REQ-014 SHALL have port inst, output, 32, meaning the instruction word to decode.
REQ-015 SHALL have port inst_pc, output, 32, meaning the PC of inst.

Function
REQ-016 SHALL complete a request transfer when imem_req and imem_ready are both 1 in a cycle; after each transfer the PC SHALL advance by 4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-017 SHALL drive imem_addr from the PC register, and hold imem_addr stable while imem_req=1 and imem_ready=0.
REQ-018 SHALL assert imem_req only when outstanding + buffer_count < DEPTH (credit rule), so the buffer never overflows.
REQ-019 SHALL record each issued PC in an in-order pending-PC queue of depth DEPTH, and pair each imem_rvalid response with the head of that queue.
REQ-020 SHALL write each non-dropped response as {pc, rdata} into the instruction buffer in the same cycle it arrives, making it visible on inst/inst_pc the next cycle (minimum fetch-to-decode latency: imem latency + 1).
REQ-021 SHALL drive inst_valid = (buffer not empty) and not redirect_valid; a transfer completes on inst_valid and inst_ready, popping the head entry.
REQ-022 SHALL drive inst = 32'h0000_0013 (NOP) and inst_pc = 0 when the buffer is empty.
REQ-023 SHALL allow push and pop in the same cycle when the buffer is full, leaving the count unchanged.
REQ-024 On redirect_valid=1 SHALL, at the clock edge: clear the buffer, load PC with {redirect_pc[31:2], 2'b00}, and set drop_cnt to the outstanding count minus any response arriving that same cycle.
REQ-025 While drop_cnt > 0, SHALL discard each imem_rvalid response and decrement drop_cnt; discarded responses never appear on inst.
REQ-026 SHALL not issue imem_req in the redirect cycle; the new-target request SHALL be issued the following cycle at the earliest.
REQ-027 SHALL ignore a request that imem accepts in the redirect cycle, and count it toward drop_cnt.
REQ-028 On back-to-back redirects SHALL let the last one win, with drop_cnt accumulating all outstanding stale responses.
REQ-029 SHALL leave imem_rvalid with no outstanding request as undefined behaviour, flagged by a simulation assertion.

Reset
REQ-030 While rst=1 (asynchronous) SHALL drive PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013, inst_pc=0, and zero all counts and drop_cnt.
REQ-031 In the first cycle after rst deasserts SHALL assert imem_req with imem_addr=RESET_PC.
REQ-032 SHALL make reset asserted mid-operation discard all buffered and in-flight state, and silently drop any responses from before reset.

Structure
REQ-033 SHALL take RESET_PC default, the NOP encoding 32'h0000_0013 and DEPTH default from the shared rv_pkg package, next to the opcode constants.
REQ-034 SHALL instantiate one sub-module, fetch_fifo: a parameterised synchronous FIFO with push, pop, flush, full, empty and count.
REQ-035 SHALL use fetch_fifo for both the instruction buffer and the pending-PC queue.

Verification
REQ-036 Reset release, imem_ready=1, 1-cycle latency, inst_ready=1 -> inst_pc sequence 0x0, 0x4, 0x8 on consecutive cycles, first inst_valid at cycle 3.
REQ-037 inst_ready=0 for 10 cycles -> exactly DEPTH(2) requests issued, then imem_req=0; on release, instructions appear in order with none lost.
REQ-038 Redirect to 0x100 with 2 requests outstanding -> the next 2 responses are dropped, then inst_pc=0x100 is the first valid instruction after the redirect.
REQ-039 redirect_pc=0x203 -> imem_addr=0x200.
REQ-040 imem_ready toggling 0/1 each cycle -> imem_addr holds stable while stalled, and the PC sequence has no gaps or duplicates.
REQ-041 rst pulsed mid-stream with 1 response in flight -> outputs return to reset values immediately, and the stale response never reaches inst.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: constants and types shared by the RV32 front end.
// Holds the opcode map, the reset fetch address, the NOP encoding, the default
// fetch-buffer depth, the instruction-buffer entry type and an alignment helper.
package rv_pkg;

    // Base opcodes (inst[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Front-end defaults
    localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] RV_NOP      = 32'h0000_0013;  // addi x0, x0, 0
    localparam int          FETCH_DEPTH = 2;

    // One instruction-buffer entry: the fetched word tagged with its PC
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    // Instruction fetch addresses are always word aligned
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small show-ahead synchronous FIFO.
// The head entry is visible on head_data whenever empty=0, so a consumer can
// look at it and pop in the same cycle.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_data     write one entry (accepted when not full, or when full
//                       and popping in the same cycle)
//   pop                 remove the head entry (ignored when empty)
//   flush               discard all entries; overrides push and pop
//   head_data           oldest entry
//   full, empty, count  occupancy status
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work too
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign head_data = mem[rd_ptr_reg];

    assign do_pop  = pop && !empty;
    // When full, a push is only safe if the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
            unique case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage carries no reset: entries are only ever read behind a valid count
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage.
// Issues word-aligned fetches to imem under a credit limit, tags responses with
// their PC through an in-order pending-PC queue, buffers them for decode, and
// handles redirects from execute by flushing and dropping stale responses.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   imem_req/imem_addr/imem_ready    fetch request handshake
//   imem_rvalid/imem_rdata           in-order fetch responses (latency >= 1)
//   redirect_valid/redirect_pc       control-flow redirect from execute
//   inst_valid/inst_ready            decode handshake
//   inst/inst_pc                     instruction word and its PC (NOP/0 when empty)
module inst_fetch
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RV_RESET_PC,
    parameter int          DEPTH    = FETCH_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;  // room for the sum of three counts

    logic [31:0]   pc_reg;
    logic [CW-1:0] drop_cnt_reg;

    // Instruction buffer
    fetch_entry_t  buf_head;
    fetch_entry_t  buf_wdata;
    logic          buf_push;
    logic          buf_pop;
    logic          buf_full;
    logic          buf_empty;
    logic [CW-1:0] buf_count;

    // Pending-PC queue (one entry per accepted, not-yet-answered request)
    logic [31:0]   pq_head;
    logic          pq_push;
    logic          pq_pop;
    logic          pq_full;
    logic          pq_empty;
    logic [CW-1:0] pq_count;

    logic          req_fire;
    logic          resp_drop;
    logic          resp_keep;
    logic [SW-1:0] occupancy;
    logic [SW-1:0] stale_after_redirect;

    // Decode side
    assign inst_valid = !buf_empty && !redirect_valid;
    assign buf_pop    = inst_valid && inst_ready;
    assign inst       = buf_empty ? RV_NOP : buf_head.word;
    assign inst_pc    = buf_empty ? 32'h0000_0000 : buf_head.pc;

    // Credit: every in-flight response (live or stale) plus every buffered
    // entry holds a slot. An entry leaving to decode this cycle frees its slot
    // now, which keeps a 1-cycle imem streaming one instruction per cycle.
    assign occupancy = SW'(pq_count) + SW'(drop_cnt_reg) + SW'(buf_count) - SW'(buf_pop);
    assign imem_req  = !rst && !redirect_valid && (occupancy < SW'(DEPTH));
    assign imem_addr = pc_reg;
    assign req_fire  = imem_req && imem_ready;

    // Stale responses ahead of the live ones are discarded first
    assign resp_drop = imem_rvalid && (drop_cnt_reg != '0);
    assign resp_keep = imem_rvalid && (drop_cnt_reg == '0) && !pq_empty;

    assign pq_push   = req_fire;
    assign pq_pop    = resp_keep;
    assign buf_push  = resp_keep && !redirect_valid;
    assign buf_wdata = '{pc: pq_head, word: imem_rdata};

    // Everything still in flight after this edge becomes stale on a redirect;
    // a response consumed this very cycle is no longer in flight.
    assign stale_after_redirect = SW'(drop_cnt_reg) + SW'(pq_count)
                                - SW'(resp_drop || resp_keep) + SW'(req_fire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            drop_cnt_reg <= '0;
        end else if (redirect_valid) begin
            pc_reg       <= word_align(redirect_pc);
            drop_cnt_reg <= CW'(stale_after_redirect);
        end else begin
            if (req_fire)  pc_reg       <= pc_reg + 32'd4;  // wraps naturally
            if (resp_drop) drop_cnt_reg <= drop_cnt_reg - CW'(1);
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (buf_wdata),
        .pop       (buf_pop),
        .flush     (redirect_valid),
        .head_data (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pend_pc (
        .clk       (clk),
        .rst       (rst),
        .push      (pq_push),
        .push_data (pc_reg),
        .pop       (pq_pop),
        .flush     (redirect_valid),
        .head_data (pq_head),
        .full      (pq_full),
        .empty     (pq_empty),
        .count     (pq_count)
    );

    // A response with nothing outstanding is a protocol violation by imem
    a_rvalid_outstanding: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (drop_cnt_reg != '0 || !pq_empty));

    // The credit limit must keep both queues from overflowing
    a_buf_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(buf_full && buf_push && !buf_pop));
    a_pq_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(pq_full && pq_push));

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // imem model
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];
    int    last_due = 0;
    int    ready_mode = 0;   // 0 always ready, 1 toggle, 2 random
    int    lat_min = 1;
    int    lat_max = 1;
    int    acc_cnt = 0;
    logic [31:0] acc_log[$];

    // Reference model: fetches in flight (stale after a redirect) and decode buffer
    typedef struct { logic [31:0] pc; bit stale; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } bent_t;
    flight_t     mflight[$];
    bent_t       mbuf[$];
    logic [31:0] mpc = RESET_PC;

    // Values seen in the last cycle
    logic        s_req, s_valid, s_rdy;
    logic [31:0] s_addr, s_inst, s_pc;

    typedef struct { logic [31:0] rpc; logic [31:0] exp_addr; int run; } redir_vec_t;
    redir_vec_t rtab[6];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: called just after a falling edge, returns at the next one.
    task automatic cycle(input logic redir, input logic [31:0] rpc, input logic iready);
        logic        e_req, e_valid, m_pop, m_acc, d_acc;
        logic [31:0] e_inst, e_pc, a_addr;
        int          occ, due;
        flight_t     f;
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_ready     = iready;
        case (ready_mode)
            0:       imem_ready = 1'b1;
            1:       imem_ready = ~imem_ready;
            2:       imem_ready = 1'($urandom_range(0, 1));
            default: imem_ready = 1'b0;
        endcase
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        e_valid = (mbuf.size() > 0) && !redir;
        m_pop   = e_valid && iready;
        occ     = mflight.size() + mbuf.size() - (m_pop ? 1 : 0);
        e_req   = (occ < DEPTH) && !redir;
        e_inst  = (mbuf.size() > 0) ? mbuf[0].word : NOP;
        e_pc    = (mbuf.size() > 0) ? mbuf[0].pc : 32'h0;
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("imem_addr", imem_addr, mpc);
        chk("inst_valid", 32'(inst_valid), 32'(e_valid));
        chk("inst", inst, e_inst);
        chk("inst_pc", inst_pc, e_pc);
        s_req = imem_req; s_valid = inst_valid; s_rdy = imem_ready;
        s_addr = imem_addr; s_inst = inst; s_pc = inst_pc;
        d_acc  = imem_req && imem_ready;
        a_addr = imem_addr;
        m_acc  = e_req && imem_ready;
        @(posedge clk);
        // imem side follows what the DUT actually did
        if (imem_rvalid) void'(mq.pop_front());
        if (d_acc) begin
            due = cyc + int'($urandom_range(lat_min, lat_max));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{a_addr, due});
            acc_cnt++;
            acc_log.push_back(a_addr);
        end
        // reference model
        if (m_pop) void'(mbuf.pop_front());
        if (imem_rvalid && mflight.size() > 0) begin
            f = mflight.pop_front();
            if (!f.stale && !redir) mbuf.push_back('{f.pc, memf(f.pc)});
        end
        if (m_acc) begin
            mflight.push_back('{mpc, redir});
            mpc = mpc + 32'd4;
        end
        if (redir) begin
            mbuf.delete();
            foreach (mflight[i]) mflight[i].stale = 1'b1;
            mpc = {rpc[31:2], 2'b00};
        end
        cyc++;
        @(negedge clk);
    endtask

    // Reset pulse starting at a falling edge; optionally delivers a stale
    // response while reset is high.
    task automatic do_reset(input bit stale_resp);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        imem_ready     = 1'b1;
        imem_rvalid    = stale_resp && (mq.size() > 0);
        imem_rdata     = (mq.size() > 0) ? memf(mq[0].addr) : 32'h0;
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst", inst, NOP);
        chk("rst_inst_pc", inst_pc, 32'h0);
        mq.delete(); mflight.delete(); mbuf.delete();
        mpc = RESET_PC;
        @(posedge clk);
        #1;
        chk("rst_hold_req", 32'(imem_req), 32'h0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        rst = 1'b0;
        cyc++;
        last_due = cyc;
    endtask

    initial begin
        int          first;
        int          n;
        logic [31:0] got[$];

        rtab[0] = '{32'h0000_0203, 32'h0000_0200, 4};
        rtab[1] = '{32'h0000_0100, 32'h0000_0100, 4};
        rtab[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 6};
        rtab[3] = '{32'h0000_0006, 32'h0000_0004, 4};
        rtab[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF8, 7};
        rtab[5] = '{32'h1234_5671, 32'h1234_5670, 4};

        @(negedge clk);

        // Reset release, streaming at 1-cycle latency
        do_reset(0);
        ready_mode = 0; lat_min = 1; lat_max = 1;
        first = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 32'h0, 1'b1);
            if (k == 1) begin
                chk("first_req", 32'(s_req), 32'h1);
                chk("first_addr", s_addr, RESET_PC);
            end
            if (s_valid && first == 0) first = k;
            if (k >= 3 && k <= 5) begin
                chk("stream_valid", 32'(s_valid), 32'h1);
                chk("stream_pc", s_pc, 32'((k - 3) * 4));
            end
        end
        chk("first_valid_cycle", 32'(first), 32'd3);

        // Decode stalled: credit limits requests to DEPTH
        do_reset(0);
        acc_cnt = 0;
        for (int k = 0; k < 10; k++) cycle(1'b0, 32'h0, 1'b0);
        chk("stall_req_count", 32'(acc_cnt), 32'(DEPTH));
        chk("stall_req_low", 32'(s_req), 32'h0);
        got.delete();
        for (int k = 0; k < 12; k++) begin
            cycle(1'b0, 32'h0, 1'b1);
            if (s_valid) got.push_back(s_pc);
        end
        chk("release_count_ge4", 32'(got.size() >= 4), 32'h1);
        foreach (got[i]) chk("release_order", got[i], 32'(i * 4));

        // Redirect with two requests outstanding
        do_reset(0);
        lat_min = 3; lat_max = 3;
        n = 0;
        while (mflight.size() < 2 && n < 20) begin
            cycle(1'b0, 32'h0, 1'b1);
            n++;
        end
        chk("two_outstanding", 32'(mflight.size()), 32'd2);
        cycle(1'b1, 32'h0000_0100, 1'b1);
        chk("redir_req_low", 32'(s_req), 32'h0);
        chk("redir_valid_low", 32'(s_valid), 32'h0);
        first = 0; n = 0;
        while (!first && n < 30) begin
            cycle(1'b0, 32'h0, 1'b1);
            if (s_valid) begin first = 1; chk("after_redir_pc", s_pc, 32'h0000_0100); end
            n++;
        end
        chk("after_redir_seen", 32'(first), 32'h1);

        // Back-to-back redirects: the last wins
        lat_min = 2; lat_max = 2;
        for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h0000_0400, 1'b1);
        cycle(1'b1, 32'h0000_0800, 1'b1);
        first = 0; n = 0;
        while (!first && n < 30) begin
            cycle(1'b0, 32'h0, 1'b1);
            if (s_valid) begin first = 1; chk("b2b_redir_pc", s_pc, 32'h0000_0800); end
            n++;
        end
        chk("b2b_redir_seen", 32'(first), 32'h1);

        // Redirect alignment and PC wrap table
        lat_min = 1; lat_max = 1;
        foreach (rtab[i]) begin
            cycle(1'b1, rtab[i].rpc, 1'b1);
            chk("tab_redir_req_low", 32'(s_req), 32'h0);
            cycle(1'b0, 32'h0, 1'b1);
            chk("tab_redir_addr", s_addr, rtab[i].exp_addr);
            for (int k = 0; k < rtab[i].run; k++) cycle(1'b0, 32'h0, 1'b1);
        end

        // imem_ready toggling: address held while stalled, no gaps or repeats
        do_reset(0);
        ready_mode = 1; imem_ready = 1'b1;
        acc_log.delete();
        for (int k = 0; k < 30; k++) begin
            logic        p_stall;
            logic [31:0] p_addr;
            p_stall = s_req && !s_rdy && (k > 0);
            p_addr  = s_addr;
            cycle(1'b0, 32'h0, 1'b1);
            if (p_stall) chk("stall_addr_hold", s_addr, p_addr);
        end
        chk("toggle_accepts_ge5", 32'(acc_log.size() >= 5), 32'h1);
        foreach (acc_log[i]) chk("toggle_pc_seq", acc_log[i], RESET_PC + 32'(i * 4));

        // Reset mid-stream with a response in flight
        ready_mode = 0; lat_min = 1; lat_max = 1;
        n = 0;
        for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 1'b1);
        while (mq.size() == 0 && n < 10) begin
            cycle(1'b0, 32'h0, 1'b1);
            n++;
        end
        chk("inflight_before_rst", 32'(mq.size() > 0), 32'h1);
        do_reset(1);
        first = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 32'h0, 1'b1);
            if (s_valid && !first) begin first = 1; chk("post_rst_first_pc", s_pc, RESET_PC); end
        end
        chk("post_rst_seen", 32'(first), 32'h1);

        // Random traffic against the reference model
        ready_mode = 2; lat_min = 1; lat_max = 3;
        for (int k = 0; k < 3000; k++) begin
            logic redir;
            redir = ($urandom_range(0, 15) == 0);
            cycle(redir, $urandom, 1'($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
